// File: rtl/muldiv_pkg.sv
// Shared constants, enumerations and sign helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_a_signed(input op_e o);
        case (o)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic op_b_signed(input op_e o);
        case (o)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared shift/accumulate register.
// Divide support is built only when MULDIV_DIV_EN is defined; otherwise divide ops report op_err.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic            rd_wren,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            op_err
);

    state_e              state_r;
    op_e                 op_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opnd_r;
    logic                sign_a_r;
    logic                sign_b_r;
    logic                busy_r;
    logic                done_r;
    logic                rd_wren_r;
    logic                op_err_r;
    logic [4:0]          rd_addr_r;
    logic [XLEN-1:0]     rd_data_r;

    op_e                 op_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   step_acc_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     fin_s;
    logic                fast_s;
    logic                fast_err_s;
    logic [XLEN-1:0]     fast_data_s;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]       div_top_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_diff_s;
`endif

    assign op_s     = op_e'(op);
    assign sign_a_s = op_a_signed(op_s) & rs1_data[XLEN-1];
    assign sign_b_s = op_b_signed(op_s) & rs2_data[XLEN-1];
    assign mag_a_s  = abs_val(rs1_data, sign_a_s);
    assign mag_b_s  = abs_val(rs2_data, sign_b_s);

    // One iteration: multiply shifts right adding the multiplicand, divide shifts left with trial subtract.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        step_acc_s = {mul_sum_s, acc_r[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        div_top_s  = acc_r[2*XLEN-1:XLEN-1];
        div_ge_s   = (div_top_s >= {1'b0, opnd_r});
        div_diff_s = div_top_s[XLEN-1:0] - opnd_r;
        if (op_r[2]) begin
            step_acc_s = {(div_ge_s ? div_diff_s : div_top_s[XLEN-1:0]), acc_r[XLEN-2:0], div_ge_s};
        end else begin
            step_acc_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
`endif
    end

    // Final sign fix-up; the low word of the negated 64-bit value doubles as the negated quotient.
    always_comb begin
        prod_s = (sign_a_r ^ sign_b_r) ? -step_acc_s : step_acc_s;
        fin_s  = {XLEN{1'b0}};
        case (op_r)
            OP_MUL:                       fin_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_s = prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              fin_s = prod_s[XLEN-1:0];
            OP_REM, OP_REMU:              fin_s = abs_val(step_acc_s[2*XLEN-1:XLEN], sign_a_r);
`endif
            default:                      fin_s = {XLEN{1'b0}};
        endcase
    end

    // Single-cycle results: divide by zero, signed overflow, or divide ops without a divider.
    always_comb begin
        fast_s      = 1'b0;
        fast_err_s  = 1'b0;
        fast_data_s = {XLEN{1'b0}};
`ifdef MULDIV_DIV_EN
        if (op[2] && (rs2_data == {XLEN{1'b0}})) begin
            fast_s      = 1'b1;
            fast_data_s = op[1] ? rs1_data : {XLEN{1'b1}};
        end else if (op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == {XLEN{1'b1}})) begin
            fast_s      = 1'b1;
            fast_data_s = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            fast_s      = 1'b0;
            fast_data_s = {XLEN{1'b0}};
        end
`else
        if (op[2]) begin
            fast_s     = 1'b1;
            fast_err_s = 1'b1;
        end else begin
            fast_s     = 1'b0;
            fast_err_s = 1'b0;
        end
`endif
    end

    // Control FSM with registered handshake and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_MUL;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_wren_r <= 1'b0;
            op_err_r  <= 1'b0;
            rd_addr_r <= 5'd0;
            rd_data_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r    <= 1'b0;
                    rd_wren_r <= 1'b0;
                    op_err_r  <= 1'b0;
                    if (start) begin
                        op_r      <= op_s;
                        rd_addr_r <= rd_addr_in;
                        sign_a_r  <= sign_a_s;
                        sign_b_r  <= sign_b_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        if (fast_s) begin
                            state_r   <= ST_DONE;
                            acc_r     <= {(2*XLEN){1'b0}};
                            opnd_r    <= {XLEN{1'b0}};
                            done_r    <= 1'b1;
                            rd_wren_r <= (rd_addr_in != 5'd0);
                            rd_data_r <= fast_data_s;
                            op_err_r  <= fast_err_s;
                        end else begin
                            state_r <= ST_BUSY;
                            acc_r   <= {{XLEN{1'b0}}, (op[2] ? mag_a_s : mag_b_s)};
                            opnd_r  <= op[2] ? mag_b_s : mag_a_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(ITERATIONS - 1)) begin
                        state_r   <= ST_DONE;
                        done_r    <= 1'b1;
                        rd_wren_r <= (rd_addr_r != 5'd0);
                        rd_data_r <= fin_s;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    rd_wren_r <= 1'b0;
                    op_err_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    rd_wren_r <= 1'b0;
                    op_err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_wren = rd_wren_r;
    assign rd_addr = rd_addr_r;
    assign rd_data = rd_data_r;
    assign op_err  = op_err_r;

endmodule
